cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Shares the single cacheline-wide memory port (256-bit, resp-based handshake) between the instruction cache and the data cache.
- Each cache's dfp port connects to a requester side of this block; the memory model or burst adapter connects to the mem side.
- One transaction outstanding at a time; round-robin arbitration; grant held until mem_resp.

Parameters:
ADDR_W, 32, byte address width of line requests
LINE_W, 256, cacheline data width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_addr  in  ADDR_W  icache line address
i_read  in  1  icache read request
i_write  in  1  icache write request (unused by icache, still arbitrated)
i_wdata  in  LINE_W  icache writeback data
i_rdata  out  LINE_W  line data returned to icache
i_resp  out  1  icache transaction complete
d_addr  in  ADDR_W  dcache line address
d_read  in  1  dcache read request
d_write  in  1  dcache writeback request
d_wdata  in  LINE_W  dcache writeback data
d_rdata  out  LINE_W  line data returned to dcache
d_resp  out  1  dcache transaction complete
mem_addr  out  ADDR_W  address to memory
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_wdata  out  LINE_W  write data to memory
mem_rdata  in  LINE_W  read data from memory
mem_resp  in  1  memory transaction complete

Behaviour:
- Reset: state=IDLE, last_grant=D (so the icache wins the first tie); all mem_* and *_resp outputs 0; *_rdata 0.
- Requester protocol: read/write/addr/wdata are held stable from assertion until the cycle resp is seen. The requester drops the request in the cycle after resp unless it issues a new transaction.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE transitions:
  - Only one requester active -> move to that requester's GNT state.
  - Both active -> grant the requester that is not last_grant.
  - Grant decision is registered, so no mem strobe is driven in IDLE.
- GNT_x behaviour:
  - mem_addr/mem_read/mem_write/mem_wdata pass combinationally from requester x.
  - mem_rdata drives x_rdata; mem_resp drives x_resp in the same cycle. The other requester's resp is held at 0.
  - On mem_resp: last_grant<=x, next state IDLE.
- Latency:
  - Minimum 1 cycle of arbitration (the IDLE cycle) plus memory latency.
  - Back-to-back transactions incur 1 bubble cycle in IDLE.
- Ungranted requester: its request is ignored (no resp), with no side effects.
- Fairness: if both request continuously, grants alternate strictly I,D,I,D.
- Read and write both asserted by one requester: illegal. The arbiter forwards both strobes unchanged. A simulation-only assertion fires.
- Requester drops its request while granted, before mem_resp: state is held until mem_resp (memory transaction already issued). Strobes follow the requester inputs.
- mem_resp while in IDLE: ignored, no resp generated.
- Reset mid-transaction: immediate return to IDLE, outputs 0. The in-flight memory transaction is abandoned; memory is reset with the same rst.

Optional Feature:
CACHE_ARB_PERF_EN
- Defined: adds three 32-bit saturating counters, readable as extra outputs perf_i_grants, perf_d_grants, perf_conflict_cycles.
  - perf_i_grants and perf_d_grants increment on each x_resp.
  - perf_conflict_cycles increments each cycle in which a requester is waiting while the other holds the grant.
  - All counters clear on rst.
- Undefined: no counters and no extra ports. Logic is identical otherwise.

Decomposition:
- cache_types package gains:
  - enum arb_state_t {ARB_IDLE, ARB_GNT_I, ARB_GNT_D}
  - typedef mem_req_t {addr, read, write, wdata}
  - typedef mem_rsp_t {rdata, resp}
- One natural sub-module: rr_arb2. It is a 2-way round-robin picker: inputs req[1:0] and last; outputs a one-hot gnt. It is combinational and reusable.
- The FSM and muxing stay in cache_mem_arbiter.

Test Plan:
- Single icache read, addr 0x0000_1000, mem_resp after 5 cycles with rdata=0xA5 repeated -> mem_read rises 1 cycle after i_read; i_resp=1 with i_rdata=0xA5.., d_resp stays 0.
- Simultaneous i_read (0x100) and d_write (0x200, wdata 0xDEAD..) from reset -> icache served first. After i_resp, 1 IDLE bubble, then mem_write with addr 0x200 and the dcache data; d_resp follows.
- Both requesting continuously for 6 transactions -> grant order I,D,I,D,I,D; each resp goes only to the owning requester.
- rst asserted 2 cycles into a granted dcache read -> next cycle mem_read=0, d_resp=0, state IDLE. The next request after reset deasserts is granted normally.
- Spurious mem_resp in IDLE with no requests -> no i_resp/d_resp, state remains IDLE.
- With CACHE_ARB_PERF_EN, run the contention test -> perf_i_grants=3, perf_d_grants=3, perf_conflict_cycles>0 matching the bench count.

Source files
------------

// File: rtl/cache_types.sv
// cache_types: shared types for the cache/memory arbiter (states, request/response bundles).
package cache_types;
    localparam int CL_ADDR_W = 32;
    localparam int CL_LINE_W = 256;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t;

    typedef struct packed {
        logic [CL_ADDR_W-1:0] addr;
        logic                 read;
        logic                 write;
        logic [CL_LINE_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [CL_LINE_W-1:0] rdata;
        logic                 resp;
    } mem_rsp_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker; last=1 means requester 1 won most recently.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one line-wide memory port between icache and dcache, round-robin.
// Optional CACHE_ARB_PERF_EN adds grant and conflict-cycle counters.
module cache_mem_arbiter
    import cache_types::*;
#(
    parameter int ADDR_W = CL_ADDR_W,
    parameter int LINE_W = CL_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
`ifdef CACHE_ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflict_cycles
`endif
);
    arb_state_t r_state, w_state_nxt;
    logic       r_last, w_last_nxt;
    logic [1:0] w_req, w_gnt;
    mem_req_t   w_ireq, w_dreq, w_sel;
    mem_rsp_t   w_rsp;

    assign w_req  = {d_read | d_write, i_read | i_write};
    assign w_ireq = '{addr: i_addr, read: i_read, write: i_write, wdata: i_wdata};
    assign w_dreq = '{addr: d_addr, read: d_read, write: d_write, wdata: d_wdata};
    assign w_rsp  = '{rdata: mem_rdata, resp: mem_resp};

    rr_arb2 u_rr (.req(w_req), .last(r_last), .gnt(w_gnt));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Grant is only released by mem_resp, even if the requester drops early.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        if (r_state == ARB_IDLE)
            w_state_nxt = w_gnt[0] ? ARB_GNT_I : w_gnt[1] ? ARB_GNT_D : ARB_IDLE;
        else if (mem_resp) begin
            w_state_nxt = ARB_IDLE;
            w_last_nxt  = (r_state == ARB_GNT_D);
        end
    end

    always_comb begin
        w_sel     = (r_state == ARB_GNT_I) ? w_ireq : (r_state == ARB_GNT_D) ? w_dreq : '0;
        mem_addr  = w_sel.addr;
        mem_read  = w_sel.read;
        mem_write = w_sel.write;
        mem_wdata = w_sel.wdata;
        i_rdata   = (r_state == ARB_GNT_I) ? w_rsp.rdata : '0;
        d_rdata   = (r_state == ARB_GNT_D) ? w_rsp.rdata : '0;
        i_resp    = (r_state == ARB_GNT_I) && w_rsp.resp;
        d_resp    = (r_state == ARB_GNT_D) && w_rsp.resp;
    end

`ifdef CACHE_ARB_PERF_EN
    logic [31:0] r_perf_i, r_perf_d, r_perf_c;
    logic        w_conflict;

    assign w_conflict = (r_state == ARB_GNT_I && w_req[1]) || (r_state == ARB_GNT_D && w_req[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_i <= '0;
            r_perf_d <= '0;
            r_perf_c <= '0;
        end else begin
            if (i_resp && !(&r_perf_i)) r_perf_i <= r_perf_i + 32'd1;
            if (d_resp && !(&r_perf_d)) r_perf_d <= r_perf_d + 32'd1;
            if (w_conflict && !(&r_perf_c)) r_perf_c <= r_perf_c + 32'd1;
        end
    end

    assign perf_i_grants        = r_perf_i;
    assign perf_d_grants        = r_perf_d;
    assign perf_conflict_cycles = r_perf_c;
`endif

`ifndef SYNTHESIS
    a_i_rw_excl: assert property (@(posedge clk) disable iff (rst) !(i_read && i_write));
    a_d_rw_excl: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
`endif
endmodule
